sc_schedule_gen: RTL and testbench

//   Generates the (stage_index, bit_index, op) step sequence for the semi-parallel SC decoder.

---
 rtl/sc_schedule_gen.sv | 120 ++++++++++++
 tb/tb_sc_schedule_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sc_schedule_gen.sv
// Step sequencer for a semi-parallel SC decoder: walks (stage, bit, f/g) tree nodes,
// folding each stage over 2**max(s-p,0) sub-cycles, one node step per non-held clock.
module sc_schedule_gen #(
  parameter int n = 3,
  parameter int p = 1,
  localparam int SW = $clog2(n),
  localparam int CW = ((n - 1 - p) > 1) ? (n - 1 - p) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          hold,
  output logic [SW-1:0] stage_index,
  output logic [n-1:0]  bit_index,
  output logic          op_g,
  output logic [CW-1:0] pe_cnt,
  output logic          sched_valid,
  output logic          last_step,
  output logic          busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [SW-1:0] S_TOP  = SW'(n - 1);
  localparam logic [n-1:0]  B_LAST = {n{1'b1}};

  state_t        state, state_nx;
  logic [SW-1:0] stage_nx;
  logic [n-1:0]  bit_nx;
  logic          op_nx;
  logic [CW-1:0] pe_nx;

  logic [n-1:0]  bit_inc;
  logic [SW-1:0] s0_next;
  logic [CW-1:0] pe_max;
  logic          run_step;
  logic          at_last;

  // Start stage of the next bit: trailing-zero count of its index.
  function automatic logic [SW-1:0] ctz(input logic [n-1:0] v);
    logic [SW-1:0] r;
    r = '0;
    for (int k = n - 1; k >= 0; k--)
      if (v[k]) r = SW'(k);
    return r;
  endfunction

  function automatic logic [CW-1:0] fold_last(input logic [SW-1:0] s);
    int sh;
    sh = (int'(s) > p) ? (int'(s) - p) : 0;
    return CW'((1 << sh) - 1);
  endfunction

  always_comb begin
    bit_inc  = bit_index + n'(1);
    s0_next  = ctz(bit_inc);
    pe_max   = fold_last(stage_index);
    run_step = (state == RUN) && !hold;
    at_last  = run_step && (stage_index == '0) && (bit_index == B_LAST) && (pe_cnt == '0);
  end

  assign sched_valid = run_step;
  assign last_step   = at_last;
  assign busy        = (state == RUN);

  always_comb begin
    state_nx = state;
    stage_nx = stage_index;
    bit_nx   = bit_index;
    op_nx    = op_g;
    pe_nx    = pe_cnt;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (run_step) begin
          if (at_last) begin
            // A start on the final executed step chains straight into a new frame.
            state_nx = start ? RUN : IDLE;
            stage_nx = S_TOP;
            bit_nx   = '0;
            op_nx    = 1'b0;
            pe_nx    = '0;
          end else if (pe_cnt != pe_max) begin
            pe_nx = pe_cnt + CW'(1);
          end else begin
            pe_nx = '0;
            if (stage_index != '0) begin
              stage_nx = stage_index - SW'(1);
              op_nx    = 1'b0;
            end else begin
              bit_nx   = bit_inc;
              stage_nx = s0_next;
              op_nx    = 1'b1;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      stage_index <= S_TOP;
      bit_index   <= '0;
      op_g        <= 1'b0;
      pe_cnt      <= '0;
    end else begin
      state       <= state_nx;
      stage_index <= stage_nx;
      bit_index   <= bit_nx;
      op_g        <= op_nx;
      pe_cnt      <= pe_nx;
    end
  end

endmodule

// File: tb/tb_sc_schedule_gen.sv
// Scoreboard bench: a tree-walk model expands each accepted frame into its step list;
// a monitor pops one expected step per cycle in which the DUT reports sched_valid.
module tb_sc_schedule_gen;
  localparam int NN = 3;
  localparam int PP = 1;
  localparam int SW = $clog2(NN);
  localparam int CW = ((NN - 1 - PP) > 1) ? (NN - 1 - PP) : 1;
  localparam int N  = 1 << NN;

  typedef struct {
    int st;
    int bi;
    bit g;
    int pc;
    bit last;
  } step_t;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0;
  logic          hold = 0;
  logic [SW-1:0] stage_index;
  logic [NN-1:0] bit_index;
  logic          op_g;
  logic [CW-1:0] pe_cnt;
  logic          sched_valid;
  logic          last_step;
  logic          busy;

  sc_schedule_gen #(.n(NN), .p(PP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .stage_index(stage_index), .bit_index(bit_index), .op_g(op_g), .pe_cnt(pe_cnt),
    .sched_valid(sched_valid), .last_step(last_step), .busy(busy)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  step_t frame[$];
  step_t sb[$];
  bit    m_run = 0;
  int    m_rem = 0;

  // Expand one frame from the decoding-tree rules.
  task automatic build_frame();
    int s0, cost;
    step_t e;
    frame.delete();
    for (int i = 0; i < N; i++) begin
      if (i == 0) s0 = NN - 1;
      else begin
        s0 = 0;
        while (((i >> s0) & 1) == 0) s0++;
      end
      for (int s = s0; s >= 0; s--) begin
        cost = 1 << ((s > PP) ? s - PP : 0);
        for (int c = 0; c < cost; c++) begin
          e.st = s; e.bi = i; e.g = (s == s0) && (i != 0); e.pc = c;
          e.last = (i == N - 1) && (s == 0) && (c == 0);
          frame.push_back(e);
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic accept();
    foreach (frame[k]) sb.push_back(frame[k]);
    m_run = 1;
    m_rem = frame.size();
  endtask

  // One clock of stimulus; the model advances on what the inputs mean this cycle.
  task automatic cyc(input bit st, input bit hd);
    @(negedge clk);
    start = st;
    hold  = hd;
    #1;
    check("sched_valid", int'(sched_valid), int'(m_run && !hd));
    check("busy", int'(busy), int'(m_run));
    if (!m_run) begin
      if (st) accept();
    end else if (!hd) begin
      m_rem--;
      if (m_rem == 0) begin
        if (st) accept();
        else m_run = 0;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".stage"}, int'(stage_index), NN - 1);
    check({tag, ".bit"}, int'(bit_index), 0);
    check({tag, ".op_g"}, int'(op_g), 0);
    check({tag, ".pe_cnt"}, int'(pe_cnt), 0);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".valid"}, int'(sched_valid), 0);
    check({tag, ".last"}, int'(last_step), 0);
  endtask

  // Monitor: each executed step must match the head of the scoreboard.
  initial begin
    step_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && sched_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL step_unexpected: got st=%0d bit=%0d g=%0d pe=%0d with empty scoreboard",
                   stage_index, bit_index, op_g, pe_cnt);
        end else begin
          e = sb.pop_front();
          if (int'(stage_index) != e.st || int'(bit_index) != e.bi || op_g != e.g ||
              int'(pe_cnt) != e.pc || last_step != e.last) begin
            bad++;
            $display("FAIL step: got st=%0d bit=%0d g=%0d pe=%0d last=%0d expected st=%0d bit=%0d g=%0d pe=%0d last=%0d",
                     stage_index, bit_index, op_g, pe_cnt, last_step,
                     e.st, e.bi, e.g, e.pc, e.last);
          end
        end
      end
    end
  end

  initial begin
    int len;
    build_frame();
    len = frame.size();
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1;

    // Plain frame.
    cyc(1, 0);
    for (int k = 0; k < len + 3; k++) cyc(0, 0);

    // Hold 3 cycles over the stage-2 steps of bit 4.
    cyc(1, 0);
    for (int k = 1; k <= len + 6; k++) cyc(0, (k >= 9 && k <= 11));

    // Start re-pulsed mid-frame.
    cyc(1, 0);
    for (int k = 1; k <= len + 3; k++) cyc(k == 7, 0);

    // Start held high: chained frames, busy never drops.
    for (int k = 0; k < 2 * len + 2; k++) cyc(1, 0);
    for (int k = 0; k < len + 3; k++) cyc(0, 0);

    // Start on a held last step is ignored.
    cyc(1, 0);
    for (int k = 1; k < len; k++) cyc(0, 0);
    cyc(1, 1);
    cyc(0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0);

    // Asynchronous reset mid-frame.
    cyc(1, 0);
    for (int k = 1; k <= 9; k++) cyc(0, 0);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    check_reset_vals("midreset");
    sb.delete();
    m_run = 0;
    m_rem = 0;
    @(negedge clk);
    rst_n = 1;
    cyc(1, 0);
    for (int k = 0; k < len + 3; k++) cyc(0, 0);

    // Random start/hold traffic.
    for (int k = 0; k < 800; k++)
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));

    // Drain with a bounded budget.
    for (int k = 0; k < 4 * len && m_run; k++) cyc(0, 0);
    cyc(0, 0);
    check("drained", int'(m_run), 0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
